// File: rtl/decoder_scan_seq_if.sv
// Control and observation bundle between the decoder scan sequencer and its controller.
// master drives start/stop/loop and observes the code; slave is the sequencer itself.
interface decoder_scan_seq_if;
    logic       start;
    logic       stop;
    logic       loop;
    logic       sel1;
    logic       sel2;
    logic       busy;
    logic       strobe;
    logic       done;
    logic [7:0] sweeps;

    modport master (
        output start, stop, loop,
        input  sel1, sel2, busy, strobe, done, sweeps
    );

    modport slave (
        input  start, stop, loop,
        output sel1, sel2, busy, strobe, done, sweeps
    );
endinterface

// File: rtl/decoder_scan_seq.sv
// Sweeps the 2-to-4 decoder selects through all codes, DWELL cycles each; SCAN_GRAY_EN selects Gray order.
// Latency 1 cycle start->first code and stop->IDLE; no backpressure, start ignored while busy.
module decoder_scan_seq #(
    parameter int DWELL   = 10,
    parameter int DWELL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    decoder_scan_seq_if.slave bus
);

    localparam logic [0:0]         S_IDLE     = 1'b0;
    localparam logic [0:0]         S_SCAN     = 1'b1;
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);
    localparam logic [1:0]         STEP_LAST  = 2'd3;

    logic [0:0]         state_q,  state_d;
    logic [1:0]         step_q,   step_d;
    logic [1:0]         sel_q,    sel_d;
    logic [DWELL_W-1:0] dwell_q,  dwell_d;
    logic               strobe_q, strobe_d;
    logic               done_q,   done_d;
    logic [7:0]         sweeps_q, sweeps_d;

    // step is the position in the sweep; sel is the code actually presented
    function automatic logic [1:0] code_map(input logic [1:0] s);
`ifdef SCAN_GRAY_EN
        return {s[1], s[1] ^ s[0]};
`else
        return s;
`endif
    endfunction

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        dwell_d  = dwell_q;
        sweeps_d = sweeps_q;
        strobe_d = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_d  = S_SCAN;
                    step_d   = 2'd0;
                    dwell_d  = '0;
                    sweeps_d = 8'd0;
                    strobe_d = 1'b1;
                end
            end
            S_SCAN: begin
                if (bus.stop) begin
                    state_d = S_IDLE;
                    step_d  = 2'd0;
                    dwell_d = '0;
                end else if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    if (step_q == STEP_LAST) begin
                        sweeps_d = (sweeps_q == 8'hFF) ? sweeps_q : sweeps_q + 8'd1;
                        step_d   = 2'd0;
                        if (bus.loop) begin
                            strobe_d = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        step_d   = step_q + 2'd1;
                        strobe_d = 1'b1;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                step_d  = 2'd0;
                dwell_d = '0;
            end
        endcase

        sel_d = code_map(step_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            step_q   <= 2'd0;
            sel_q    <= 2'd0;
            dwell_q  <= '0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            sweeps_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            sel_q    <= sel_d;
            dwell_q  <= dwell_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
            sweeps_q <= sweeps_d;
        end
    end

    assign bus.sel1   = sel_q[0];
    assign bus.sel2   = sel_q[1];
    assign bus.busy   = (state_q == S_SCAN);
    assign bus.strobe = strobe_q;
    assign bus.done   = done_q;
    assign bus.sweeps = sweeps_q;

endmodule

// File: tb/tb_decoder_scan_seq.sv
// Scoreboard bench for decoder_scan_seq: a position-in-sweep reference model queues expected outputs,
// a negedge monitor pops and compares every cycle.
module tb_decoder_scan_seq;

    localparam int DWELL   = 3;
    localparam int DWELL_W = 8;
    localparam int SWEEP   = 4 * DWELL;

    logic clk;
    logic rst;

    decoder_scan_seq_if bus_if ();

    decoder_scan_seq #(
        .DWELL   (DWELL),
        .DWELL_W (DWELL_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: in_scan flag plus cycle position within the current sweep.
    bit         m_scan;
    int         m_pos;
    int         m_sweeps;
    bit         m_done;
    logic [1:0] code_seq [4];

    logic [12:0] exp_q [$];
    int          n_tests;
    int          n_fail;
    int          cyc;

    function automatic logic [12:0] model_out();
        int         idx;
        logic [1:0] code;
        logic       strb;
        idx  = m_scan ? (m_pos / DWELL) : 0;
        code = code_seq[idx];
        strb = m_scan && ((m_pos % DWELL) == 0);
        return {code[1], code[0], m_scan, strb, m_done, 8'(m_sweeps)};
    endfunction

    task automatic step(input bit r, input bit s, input bit p, input bit l);
        rst           = r;
        bus_if.start  = s;
        bus_if.stop   = p;
        bus_if.loop   = l;
        m_done = 1'b0;
        if (r) begin
            m_scan   = 1'b0;
            m_pos    = 0;
            m_sweeps = 0;
        end else if (!m_scan) begin
            if (s && !p) begin
                m_scan   = 1'b1;
                m_pos    = 0;
                m_sweeps = 0;
            end
        end else if (p) begin
            m_scan = 1'b0;
            m_pos  = 0;
        end else begin
            m_pos++;
            if (m_pos == SWEEP) begin
                m_pos    = 0;
                m_sweeps = (m_sweeps < 255) ? m_sweeps + 1 : 255;
                if (!l) begin
                    m_scan = 1'b0;
                    m_done = 1'b1;
                end
            end
        end
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
    endtask

    // Monitor: one comparison per cycle, after the edge that produced the queued expectation.
    initial begin
        logic [12:0] exp_v;
        logic [12:0] act_v;
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                act_v = {bus_if.sel2, bus_if.sel1, bus_if.busy, bus_if.strobe,
                         bus_if.done, bus_if.sweeps};
                n_tests++;
                if (act_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL outputs cycle %0d: got sel2sel1=%b%b busy=%b strobe=%b done=%b sweeps=%0d, expected sel2sel1=%b%b busy=%b strobe=%b done=%b sweeps=%0d",
                             cyc, act_v[12], act_v[11], act_v[10], act_v[9], act_v[8], act_v[7:0],
                             exp_v[12], exp_v[11], exp_v[10], exp_v[9], exp_v[8], exp_v[7:0]);
                end
            end
        end
    end

    initial begin
`ifdef SCAN_GRAY_EN
        code_seq[0] = 2'b00; code_seq[1] = 2'b01; code_seq[2] = 2'b11; code_seq[3] = 2'b10;
`else
        code_seq[0] = 2'b00; code_seq[1] = 2'b01; code_seq[2] = 2'b10; code_seq[3] = 2'b11;
`endif
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        m_scan  = 1'b0;
        m_pos   = 0;
        m_sweeps = 0;
        m_done  = 1'b0;
        rst          = 1'b1;
        bus_if.start = 1'b0;
        bus_if.stop  = 1'b0;
        bus_if.loop  = 1'b0;

        // reset held with start high must not launch a sweep
        repeat (3) step(1, 1, 0, 0);
        repeat (2) step(0, 0, 0, 0);

        // single sweep
        step(0, 1, 0, 0);
        repeat (SWEEP + 3) step(0, 0, 0, 0);

        // loop mode: three sweeps then stop
        step(0, 1, 0, 1);
        repeat (3 * SWEEP) step(0, 0, 0, 1);
        step(0, 0, 1, 1);
        repeat (2) step(0, 0, 0, 0);

        // stop coincident with a code advance
        step(0, 1, 0, 1);
        for (int i = 0; i < SWEEP && m_pos != DWELL - 1; i++) step(0, 0, 0, 1);
        step(0, 0, 1, 1);
        repeat (2) step(0, 0, 0, 0);

        // start and stop together in IDLE
        step(0, 1, 1, 0);
        repeat (2) step(0, 0, 0, 0);

        // start held through two sweeps: restart taken in the done cycle
        repeat (2 * SWEEP + 4) step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);

        // reset mid-sweep at the third code
        step(0, 1, 0, 0);
        for (int i = 0; i < SWEEP && m_pos != 2 * DWELL; i++) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0);

        // sweep counter saturation, then a normal finish
        step(0, 1, 0, 1);
        repeat (257 * SWEEP) step(0, 0, 0, 1);
        repeat (SWEEP + 2) step(0, 0, 0, 0);

        // randomized traffic
        repeat (1500) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 19) == 0),
                 bit'($urandom_range(0, 1)));
        end
        repeat (3) step(0, 0, 1, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/decoder_scan_seq.md
# decoder_scan_seq

Stimulus sequencer placed directly upstream of the 2-to-4 `decoder`. It drives the decoder's two select inputs through all four input codes, holding each code for a programmable number of clock cycles. It supports single-sweep and continuous loop modes, with a start/busy/done handshake and a per-code strobe so downstream checkers know when to sample the decoder outputs.

## Interface
Parameters:
- `DWELL`, 10, cycles each code is held; legal range 1..2^DWELL_W-1; 0 is illegal.
- `DWELL_W`, 8, width of the internal dwell counter.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  synchronous reset, active-high.
- `start`  in  1  begin a sweep; sampled only in IDLE.
- `stop`  in  1  abort a sweep; sampled in SCAN and in IDLE.
- `loop`  in  1  1 = wrap to code 0 after code 3; 0 = single sweep; sampled at every code-3 exit.
- `sel1`  out  1  code LSB; connects to decoder `inp1`.
- `sel2`  out  1  code MSB; connects to decoder `inp2`.
- `busy`  out  1  high while in SCAN.
- `strobe`  out  1  1-cycle pulse on the first cycle of each new code.
- `done`  out  1  1-cycle pulse after a sweep completes normally.
- `sweeps`  out  8  count of completed sweeps since `start`; saturates at 255.

## Operation
- States: IDLE, SCAN.
- **Reset.** `rst` forces IDLE at the next edge. The reset values are: `sel1`=0, `sel2`=0, `busy`=0, `strobe`=0, `done`=0, `sweeps`=0, dwell counter=0. Reset has priority over every other input, including mid-sweep.
- **IDLE.**
  - `start`=1 and `stop`=0 moves to SCAN. On that transition: code=00, dwell=0, `sweeps`=0, `strobe`=1 on the next cycle.
  - `start`=1 and `stop`=1 together: the FSM stays in IDLE.
- **SCAN.**
  - The dwell counter increments each cycle.
  - When dwell = DWELL-1, the counter clears and the code advances to the next code in sequence order.
  - `strobe`=1 in the first cycle of every new code.
- **Sequence order**, as {sel2,sel1}: 00, 01, 10, 11 (binary).
- **Code-3 exit** (dwell = DWELL-1 while code = 11):
  - `sweeps` increments, saturating at 255.
  - If `loop`=1: the code wraps to 00 with `strobe`, and the FSM stays in SCAN.
  - If `loop`=0: the FSM returns to IDLE with code=00 and `done`=1 for one cycle.
- **Abort.** `stop`=1 in SCAN returns to IDLE at the next edge with code=00.
  - No `done` pulse and no `strobe`.
  - `sweeps` keeps its value.
  - `stop` outranks a simultaneous code advance or code-3 exit.
- `start` is ignored while `busy`=1.
- `start` in the `done` cycle is accepted, because the FSM is already in IDLE.
- The outputs are glitch-free: `sel1`, `sel2`, `busy`, `strobe` and `done` are all registered.

## Timing
- Let `start` be sampled at edge k.
  - `busy`=1, code=00 and `strobe`=1 are visible from edge k+1.
- Code n (n = 0..3) is held from edge k+1+n·DWELL through edge k+(n+1)·DWELL.
- **Single sweep:** at edge k+1+4·DWELL, `busy`=0, `done`=1, code=00 and `sweeps`=1.
- **Loop mode:** code 00 reappears at edge k+1+4·DWELL with `strobe`=1 and `sweeps`=1. Code 00 then recurs every 4·DWELL cycles.
- **`stop` sampled at edge m:** the FSM is in IDLE and code=00 from edge m+1.
- **DWELL=1:** the code changes every cycle and `strobe` stays high continuously while in SCAN.
- Latency from `start` to first code: 1 cycle.
- Latency from `stop` to IDLE: 1 cycle.

## Configuration
- `SCAN_GRAY_EN`:
  - Defined: the sequence order is Gray, 00, 01, 11, 10, so only one select line toggles per step. The last code of a sweep is 10, and the code-3 exit applies at code 10.
  - Undefined: the binary order 00, 01, 10, 11 applies.
- All timing, handshake and counter behaviour is identical in both builds.

## Test plan
- **Reset:** hold `rst` 3 cycles with `start`=1 -> all outputs 0 and no transition to SCAN while `rst` is high.
- **Single sweep, DWELL=10, `loop`=0:** pulse `start` -> codes 00, 01, 10, 11 held 10 cycles each; `strobe` at 4 edges spaced 10 apart; `done` 41 cycles after `start`; `sweeps`=1; `busy` high for exactly 40 cycles.
- **Loop mode, DWELL=2, `loop`=1, run 3 sweeps then `stop`:**
  - `sweeps`=3, no `done`, code=00 one cycle after `stop`.
  - A second, separate check: `stop` asserted in the same cycle as a code advance -> IDLE wins.
- **Handshake corners:**
  - `start`+`stop` together in IDLE -> stays IDLE.
  - `start` held high throughout the sweep -> ignored while busy; a new sweep starts in the `done` cycle, with `strobe` at the next edge.
- **`rst` mid-sweep at code 10** -> next cycle all outputs 0, FSM in IDLE, `sweeps`=0.
- **Build with `SCAN_GRAY_EN`, DWELL=1** -> codes 00, 01, 11, 10 on consecutive cycles; `done` on the 5th cycle after `start`; exactly one of `sel1`/`sel2` toggles per step.
